// File: rtl/kmeans_centroid_update_k4n2_if.sv
// Bus between the k=4, 2-dim centroid updater and its controller/accumulator.
// k[c][d] / new_k[c][d] carry coordinate d of centroid c.
interface kmeans_centroid_update_k4n2_if #(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
);
    logic                                   start;
    logic [3:0][1:0][input_data_width-1:0] k;
    logic                                   rd_acc_en;
    logic [1:0]                             rd_acc_centroid;
    logic [acc_width-1:0]                   acc0_output;
    logic [acc_width-1:0]                   acc1_output;
    logic [input_data_qty_bit_width-1:0]    acc_counter_output;
    logic                                   acc_rst;
    logic [3:0][1:0][input_data_width-1:0] new_k;
    logic                                   busy;
    logic                                   done;
    logic                                   changed;

    modport master (
        output start, k, acc0_output, acc1_output, acc_counter_output,
        input  rd_acc_en, rd_acc_centroid, acc_rst, new_k, busy, done, changed
    );

    modport slave (
        input  start, k, acc0_output, acc1_output, acc_counter_output,
        output rd_acc_en, rd_acc_centroid, acc_rst, new_k, busy, done, changed
    );
endinterface

// File: rtl/kmeans_centroid_update_k4n2.sv
// Sweeps the 4 accumulator lines, divides sums by counts (restoring, one divider
// per dimension), writes new centroids, clears the accumulators, reports motion.
module kmeans_centroid_update_k4n2 #(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) (
    input  logic clk,
    input  logic rst,
    kmeans_centroid_update_k4n2_if.slave bus
);
    localparam int DW = input_data_width;
    localparam int QW = input_data_qty_bit_width;
    localparam int AW = acc_width;
    localparam int CW = $clog2(AW);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DIV, S_WR, S_CLR, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [1:0]                 r_c, w_next_c;
    logic [CW-1:0]              r_div_cnt;
    logic [QW-1:0]              r_cnt;
    logic [1:0][AW-1:0]         r_quo, w_quo_nxt;
    logic [1:0][AW-1:0]         r_rem, w_rem_nxt;
    logic [1:0][AW:0]           w_sh;
    logic [AW:0]                w_dvs;
    logic [1:0][DW-1:0]         w_wval;
    logic                       w_diff;

    logic                       r_rd_acc_en, r_acc_rst, r_busy, r_done, r_changed;
    logic [1:0]                 r_rd_acc_centroid;
    logic [3:0][1:0][DW-1:0]    r_new_k;

    assign w_dvs = {1'b0, AW'(r_cnt)};

    always_comb begin
        w_next   = r_state;
        w_next_c = r_c;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_next   = S_RD;
                w_next_c = 2'd0;
            end
            S_RD:   w_next = (bus.acc_counter_output == '0) ? S_WR : S_DIV;
            S_DIV:  if (r_div_cnt == CW'(AW-1)) w_next = S_WR;
            S_WR:   if (r_c == 2'd3) w_next = S_CLR;
                    else begin
                        w_next   = S_RD;
                        w_next_c = r_c + 2'd1;
                    end
            S_CLR:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One restoring step per dimension; the quotient register shifts the dividend out at the top.
    always_comb begin
        w_sh      = '0;
        w_rem_nxt = '0;
        w_quo_nxt = '0;
        w_wval    = '0;
        w_diff    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            w_sh[d] = {r_rem[d], r_quo[d][AW-1]};
            if (w_sh[d] >= w_dvs) begin
                w_rem_nxt[d] = AW'(w_sh[d] - w_dvs);
                w_quo_nxt[d] = {r_quo[d][AW-2:0], 1'b1};
            end else begin
                w_rem_nxt[d] = w_sh[d][AW-1:0];
                w_quo_nxt[d] = {r_quo[d][AW-2:0], 1'b0};
            end
            if (r_cnt == '0)                w_wval[d] = bus.k[r_c][d];
            else if ((r_quo[d] >> DW) != '0) w_wval[d] = '1;
            else                            w_wval[d] = r_quo[d][DW-1:0];
            if (w_wval[d] != bus.k[r_c][d]) w_diff = 1'b1;
        end
    end

    // Control outputs are registered images of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_c               <= 2'd0;
            r_div_cnt         <= '0;
            r_cnt             <= '0;
            r_quo             <= '0;
            r_rem             <= '0;
            r_rd_acc_en       <= 1'b0;
            r_rd_acc_centroid <= 2'd0;
            r_acc_rst         <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_changed         <= 1'b0;
            r_new_k           <= '0;
        end else begin
            r_state           <= w_next;
            r_c               <= w_next_c;
            r_rd_acc_en       <= (w_next == S_RD);
            r_rd_acc_centroid <= w_next_c;
            r_acc_rst         <= (w_next == S_CLR);
            r_done            <= (w_next == S_DONE);
            r_busy            <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: if (bus.start) r_changed <= 1'b0;
                S_RD: begin
                    r_cnt     <= bus.acc_counter_output;
                    r_quo[0]  <= bus.acc0_output;
                    r_quo[1]  <= bus.acc1_output;
                    r_rem     <= '0;
                    r_div_cnt <= '0;
                end
                S_DIV: begin
                    r_quo     <= w_quo_nxt;
                    r_rem     <= w_rem_nxt;
                    r_div_cnt <= r_div_cnt + CW'(1);
                end
                S_WR: begin
                    r_new_k[r_c] <= w_wval;
                    if (w_diff) r_changed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_acc_en       = r_rd_acc_en;
    assign bus.rd_acc_centroid = r_rd_acc_centroid;
    assign bus.acc_rst         = r_acc_rst;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.changed         = r_changed;
    assign bus.new_k           = r_new_k;
endmodule

// File: tb/tb_kmeans_centroid_update_k4n2.sv
// Bench for the centroid updater: directed table, reset-in-DIV sequence, random sweeps.
module tb_kmeans_centroid_update_k4n2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kmeans_centroid_update_k4n2_if #(.input_data_width(8), .input_data_qty_bit_width(8),
                                     .acc_width(16)) bus ();
    kmeans_centroid_update_k4n2 #(.input_data_width(8), .input_data_qty_bit_width(8),
                                  .acc_width(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Accumulator block stand-in: combinational read of the addressed line.
    logic [3:0][1:0][15:0] tb_sum;
    logic [3:0][7:0]       tb_cnt;
    always_comb begin
        bus.acc0_output        = tb_sum[bus.rd_acc_centroid][0];
        bus.acc1_output        = tb_sum[bus.rd_acc_centroid][1];
        bus.acc_counter_output = tb_cnt[bus.rd_acc_centroid];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][1:0][15:0] sum;
        logic [3:0][7:0]       cnt;
        logic [3:0][1:0][7:0]  old;
        logic [3:0][1:0][7:0]  expk;
        logic                  chg;
        int                    dcyc;
        int                    pulse_at;
    } vec_t;
    vec_t vec[6];

    task automatic set_c(input int i, input int c, input int s0, input int s1, input int n,
                         input int o0, input int o1, input int e0, input int e1);
        vec[i].sum[c][0]  = 16'(s0);
        vec[i].sum[c][1]  = 16'(s1);
        vec[i].cnt[c]     = 8'(n);
        vec[i].old[c][0]  = 8'(o0);
        vec[i].old[c][1]  = 8'(o1);
        vec[i].expk[c][0] = 8'(e0);
        vec[i].expk[c][1] = 8'(e1);
    endtask

    // Reference: floor division with saturation, empty clusters keep their position.
    task automatic model(output logic [3:0][1:0][7:0] e, output logic chg, output int dcyc);
        int q;
        chg  = 1'b0;
        dcyc = 2;
        for (int c = 0; c < 4; c++) begin
            dcyc += (tb_cnt[c] == 0) ? 2 : 18;
            for (int d = 0; d < 2; d++) begin
                if (tb_cnt[c] == 0) e[c][d] = bus.k[c][d];
                else begin
                    q = int'(tb_sum[c][d]) / int'(tb_cnt[c]);
                    e[c][d] = (q > 255) ? 8'hFF : 8'(q);
                end
                if (e[c][d] != bus.k[c][d]) chg = 1'b1;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input logic [3:0][1:0][7:0] expk,
                             input logic exp_chg, input int exp_done, input int pulse_at);
        int rd_cyc[4];
        int t, cyc, perr, nrd, nrst, rst_at, exp_c;
        logic exp_en, got_done;
        t = 1;
        for (int c = 0; c < 4; c++) begin
            rd_cyc[c] = t;
            t += (tb_cnt[c] == 0) ? 2 : 18;
        end
        perr = 0; nrd = 0; nrst = 0; rst_at = -1; got_done = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= 200) begin
            exp_en = 1'b0;
            exp_c  = 0;
            for (int c = 0; c < 4; c++) if (rd_cyc[c] == cyc) begin exp_en = 1'b1; exp_c = c; end
            if (bus.rd_acc_en !== exp_en) perr++;
            if (bus.rd_acc_en === 1'b1) begin
                nrd++;
                if (bus.rd_acc_centroid != 2'(exp_c)) perr++;
            end
            if (bus.acc_rst === 1'b1) begin nrst++; rst_at = cyc; end
            if (bus.busy !== 1'b1) perr++;
            if (bus.done === 1'b1) begin got_done = 1'b1; break; end
            bus.start = (cyc == pulse_at);
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        chk({tag, " done_seen"}, got_done, 1);
        chk({tag, " done_cycle"}, cyc, exp_done);
        chk({tag, " rd_protocol_errs"}, perr, 0);
        chk({tag, " rd_pulses"}, nrd, 4);
        chk({tag, " acc_rst_pulses"}, nrst, 1);
        chk({tag, " acc_rst_cycle"}, rst_at, exp_done - 1);
        for (int c = 0; c < 4; c++)
            chk($sformatf("%s new_k%0d", tag, c), bus.new_k[c], expk[c]);
        chk({tag, " changed"}, bus.changed, exp_chg);
        @(posedge clk); #1;
        chk({tag, " busy_after"}, bus.busy, 0);
        chk({tag, " done_after"}, bus.done, 0);
        chk({tag, " changed_hold"}, bus.changed, exp_chg);
    endtask

    task automatic load(input int i);
        tb_sum = vec[i].sum;
        tb_cnt = vec[i].cnt;
        bus.k  = vec[i].old;
    endtask

    logic [3:0][1:0][7:0] m_exp;
    logic                 m_chg;
    int                   m_dcyc;
    int                   nacc;

    always @(posedge clk) if (bus.acc_rst === 1'b1) nacc <= nacc + 1;

    initial begin
        bus.start = 1'b0;
        bus.k     = '0;
        tb_sum    = '0;
        tb_cnt    = '0;
        nacc      = 0;

        // Nominal
        set_c(0, 0, 40, 80, 4, 0, 0, 10, 20);
        set_c(0, 1, 10, 12, 2, 0, 0, 5, 6);
        set_c(0, 2, 100, 55, 5, 0, 0, 20, 11);
        set_c(0, 3, 200, 7, 1, 0, 0, 200, 7);
        vec[0].chg = 1'b1; vec[0].dcyc = 74; vec[0].pulse_at = 10;
        // Empty cluster c2
        vec[1] = vec[0];
        set_c(1, 2, 100, 55, 0, 7, 9, 7, 9);
        vec[1].dcyc = 58; vec[1].pulse_at = 40;
        // Truncation, saturation, maximum counter
        set_c(2, 0, 10, 20, 3, 0, 0, 3, 6);
        set_c(2, 1, 16'hFFFF, 5, 1, 0, 0, 8'hFF, 5);
        set_c(2, 2, 16'h00FF, 16'h00FF, 8'hFF, 0, 0, 1, 1);
        set_c(2, 3, 0, 0, 7, 0, 0, 0, 0);
        vec[2].chg = 1'b1; vec[2].dcyc = 74; vec[2].pulse_at = 0;
        // Converged
        set_c(3, 0, 40, 80, 4, 10, 20, 10, 20);
        set_c(3, 1, 10, 12, 2, 5, 6, 5, 6);
        set_c(3, 2, 100, 55, 5, 20, 11, 20, 11);
        set_c(3, 3, 200, 7, 1, 200, 7, 200, 7);
        vec[3].chg = 1'b0; vec[3].dcyc = 74; vec[3].pulse_at = 73;
        // Only k3d1 perturbed by +1
        vec[4] = vec[3];
        set_c(4, 3, 200, 7, 1, 200, 8, 200, 7);
        vec[4].chg = 1'b1;
        // All clusters empty
        set_c(5, 0, 5, 5, 0, 1, 2, 1, 2);
        set_c(5, 1, 5, 5, 0, 3, 4, 3, 4);
        set_c(5, 2, 5, 5, 0, 5, 6, 5, 6);
        set_c(5, 3, 5, 5, 0, 7, 8, 7, 8);
        vec[5].chg = 1'b0; vec[5].dcyc = 10; vec[5].pulse_at = 3;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset changed", bus.changed, 0);
        chk("reset rd_acc_en", bus.rd_acc_en, 0);
        chk("reset rd_acc_centroid", bus.rd_acc_centroid, 0);
        chk("reset acc_rst", bus.acc_rst, 0);
        chk("reset new_k", bus.new_k, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            load(i);
            run_sweep($sformatf("vec%0d", i), vec[i].expk, vec[i].chg, vec[i].dcyc, vec[i].pulse_at);
        end

        // Reset while dividing centroid 1 (its RD is cycle 19, DIV cycles 20..35).
        load(0);
        nacc = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (24) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstdiv busy", bus.busy, 0);
        chk("rstdiv done", bus.done, 0);
        chk("rstdiv changed", bus.changed, 0);
        chk("rstdiv rd_acc_en", bus.rd_acc_en, 0);
        chk("rstdiv rd_acc_centroid", bus.rd_acc_centroid, 0);
        chk("rstdiv acc_rst", bus.acc_rst, 0);
        chk("rstdiv new_k", bus.new_k, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstdiv idle_busy", bus.busy, 0);
        chk("rstdiv acc_rst_pulses", nacc, 0);
        run_sweep("after_rst", vec[0].expk, vec[0].chg, vec[0].dcyc, 0);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                tb_cnt[c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                for (int d = 0; d < 2; d++) begin
                    tb_sum[c][d] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                               : 16'($urandom_range(0, 2000));
                    bus.k[c][d]  = 8'($urandom_range(0, 255));
                end
            end
            if (r == 7) begin
                tb_cnt[3] = 8'd0;
                bus.k     = '0;
            end
            model(m_exp, m_chg, m_dcyc);
            run_sweep($sformatf("rand%0d", r), m_exp, m_chg, m_dcyc, $urandom_range(0, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
